// File: rtl/gpio_pkg.sv
// Shared constants for the MMIO GPIO controller: bus widths, register offsets,
// bus FSM encoding and the default register window base.
package gpio_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic [3:0] OFF_SW    = 4'h0;
    localparam logic [3:0] OFF_LED   = 4'h4;
    localparam logic [3:0] OFF_EDGE  = 4'h8;
    localparam logic [3:0] OFF_IRQEN = 4'hC;

    localparam logic [ADDR_W-1:0] DEFAULT_BASE_ADDR = 32'hFFFF_0000;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } bus_state_e;

endpackage

// File: rtl/mmio_gpio_ctrl_if.sv
// Load/store bus between the core and the GPIO register window.
interface mmio_gpio_ctrl_if;

    logic                          bus_req;
    logic                          bus_we;
    logic [gpio_pkg::ADDR_W-1:0]   bus_addr;
    logic [gpio_pkg::DATA_W-1:0]   bus_wdata;
    logic [gpio_pkg::DATA_W-1:0]   bus_rdata;
    logic                          bus_ready;
    logic                          bus_err;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ready, bus_err
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ready, bus_err
    );

endinterface

// File: rtl/gpio_debounce.sv
// Two-flop synchronizer plus a shared debounce counter; stable only moves after
// the synchronized value has disagreed with it for DEBOUNCE_CYCLES cycles.
module gpio_debounce #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable,
    output logic [WIDTH-1:0] changed
);

    localparam int unsigned      CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync;
    logic [CNT_W-1:0] cnt;
    logic             settle;

    // settle marks the cycle whose closing edge loads sync into stable
    assign settle  = (sync != stable) && (cnt == CNT_LAST);
    assign changed = settle ? (sync ^ stable) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= '0;
            sync   <= '0;
            stable <= '0;
            cnt    <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
            if (sync == stable) begin
                cnt <= '0;
            end else if (settle) begin
                stable <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mmio_gpio_ctrl.sv
// Memory-mapped GPIO controller: 16-byte register window, two-state bus
// handshake, debounced switch inputs with sticky change flags, LEDs and irq.
module mmio_gpio_ctrl
    import gpio_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR       = DEFAULT_BASE_ADDR,
    parameter int unsigned       DEBOUNCE_CYCLES = 4,
    parameter int unsigned       SW_WIDTH        = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    mmio_gpio_ctrl_if.slave     bus,
    input  logic [SW_WIDTH-1:0] switches,
    output logic [SW_WIDTH-1:0] leds,
    output logic                irq
);

    bus_state_e          state;
    logic [SW_WIDTH-1:0] led_q;
    logic [SW_WIDTH-1:0] edge_q;
    logic [SW_WIDTH-1:0] irq_en_q;
    logic [SW_WIDTH-1:0] stable;
    logic [SW_WIDTH-1:0] changed;
    logic [SW_WIDTH-1:0] wdata;
    logic [SW_WIDTH-1:0] w1c;
    logic [3:0]          offset;
    logic [DATA_W-1:0]   rd_val;
    logic                hit;
    logic                wr_en;
    logic                unused_wdata;

    gpio_debounce #(
        .WIDTH           (SW_WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw     (switches),
        .stable  (stable),
        .changed (changed)
    );

    assign unused_wdata = ^bus.bus_wdata;
    assign leds         = led_q;

    // Address decode and read mux for the access presented in IDLE
    always_comb begin
        offset = bus.bus_addr[3:0];
        hit    = (bus.bus_addr[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4]) &&
                 (bus.bus_addr[1:0] == 2'b00);
        wr_en  = (state == IDLE) && bus.bus_req && bus.bus_we && hit;
        wdata  = bus.bus_wdata[SW_WIDTH-1:0];
        w1c    = (wr_en && (offset == OFF_EDGE)) ? wdata : '0;
        case (offset)
            OFF_SW:    rd_val = DATA_W'(stable);
            OFF_LED:   rd_val = DATA_W'(led_q);
            OFF_EDGE:  rd_val = DATA_W'(edge_q);
            OFF_IRQEN: rd_val = DATA_W'(irq_en_q);
            default:   rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.bus_ready <= 1'b0;
            bus.bus_err   <= 1'b0;
            bus.bus_rdata <= '0;
        end else if (state == IDLE) begin
            if (bus.bus_req) begin
                state         <= RESP;
                bus.bus_ready <= 1'b1;
                bus.bus_err   <= !hit;
                bus.bus_rdata <= (hit && !bus.bus_we) ? rd_val : '0;
            end
        end else begin
            state         <= IDLE;
            bus.bus_ready <= 1'b0;
            bus.bus_err   <= 1'b0;
            bus.bus_rdata <= '0;
        end
    end

    // A hardware change flag overrides a same-cycle write-1-to-clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q    <= '0;
            irq_en_q <= '0;
            edge_q   <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_en && (offset == OFF_LED))   led_q    <= wdata;
            if (wr_en && (offset == OFF_IRQEN)) irq_en_q <= wdata;
            edge_q <= (edge_q & ~w1c) | changed;
            irq    <= |(edge_q & irq_en_q);
        end
    end

endmodule

// File: tb/tb_mmio_gpio_ctrl.sv
// Scoreboard bench for mmio_gpio_ctrl: directed scenarios plus random traffic
// against a register-level reference model of the GPIO window.
module tb_mmio_gpio_ctrl;

    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam int unsigned DEB  = 4;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  leds;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] switches;
    logic [7:0] leds;
    logic       irq;
    logic       irq_resp;

    int total = 0;
    int bad   = 0;

    exp_t q[$];
    exp_t mon_e;
    // model registers: 0 SW, 1 LED, 2 EDGE, 3 IRQ_EN
    logic [7:0] m[4];

    mmio_gpio_ctrl_if bus_if ();

    mmio_gpio_ctrl #(
        .BASE_ADDR       (BASE),
        .DEBOUNCE_CYCLES (DEB),
        .SW_WIDTH        (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_if),
        .switches (switches),
        .leds     (leds),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic irq_model();
        return |(m[2] & m[3]);
    endfunction

    // Issue one access; expectation is derived from the register model first
    task automatic bus_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        logic hit;
        int unsigned idx;
        hit = (addr >= BASE) && ((addr - BASE) < 32'd16) && ((addr % 4) == 0);
        e.rdata = '0;
        e.err   = !hit;
        if (hit) begin
            idx = (addr - BASE) / 4;
            if (!we) e.rdata = {24'b0, m[idx]};
            else if (idx == 1) m[1] = wdata[7:0];
            else if (idx == 2) m[2] = m[2] & ~wdata[7:0];
            else if (idx == 3) m[3] = wdata[7:0];
        end
        e.leds = m[1];
        q.push_back(e);
        bus_if.bus_req   = 1'b1;
        bus_if.bus_we    = we;
        bus_if.bus_addr  = addr;
        bus_if.bus_wdata = wdata;
        @(posedge clk); #1;
        bus_if.bus_req = 1'b0;
        @(negedge clk);
        irq_resp = irq;
        @(posedge clk); #1;
    endtask

    task automatic settle_switches(input logic [7:0] v);
        switches = v;
        repeat (DEB + 6) @(posedge clk);
        #1;
        m[2] = m[2] | (m[0] ^ v);
        m[0] = v;
    endtask

    // Monitor: pop one expectation per ready pulse; bus must be quiet otherwise
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_if.bus_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ready: got ready=1 want no pending access");
                end else begin
                    mon_e = q.pop_front();
                    chk("rdata", 64'(bus_if.bus_rdata), 64'(mon_e.rdata));
                    chk("err",   64'(bus_if.bus_err),   64'(mon_e.err));
                    chk("leds_at_ready", 64'(leds),     64'(mon_e.leds));
                end
            end else begin
                chk("idle_quiet", 64'({bus_if.bus_err, bus_if.bus_rdata}), 64'(0));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [7:0]  v;
        for (int i = 0; i < 4; i++) m[i] = '0;
        rst_n            = 1'b0;
        switches         = 8'hFF;
        bus_if.bus_req   = 1'b0;
        bus_if.bus_we    = 1'b0;
        bus_if.bus_addr  = '0;
        bus_if.bus_wdata = '0;
        irq_resp         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_leds",  64'(leds), 64'(0));
        chk("rst_irq",   64'(irq), 64'(0));
        chk("rst_ready", 64'(bus_if.bus_ready), 64'(0));
        rst_n = 1'b1;

        // SW reads committed on edges 1, 3, 5 after release still see 0
        bus_op(1'b0, BASE + 32'h0, '0);
        bus_op(1'b0, BASE + 32'h0, '0);
        bus_op(1'b0, BASE + 32'h0, '0);
        repeat (10) @(posedge clk);
        #1;
        m[2] = m[2] | (m[0] ^ 8'hFF);
        m[0] = 8'hFF;
        bus_op(1'b0, BASE + 32'h0, '0);
        bus_op(1'b0, BASE + 32'h8, '0);
        bus_op(1'b1, BASE + 32'h8, 32'hFFFF_FFFF);
        bus_op(1'b0, BASE + 32'h8, '0);

        // 0xAA: a read committed DEB+2 edges after the change still sees the old value
        switches = 8'hAA;
        repeat (DEB + 1) @(posedge clk);
        #1;
        bus_op(1'b0, BASE + 32'h0, '0);
        m[2] = m[2] | (m[0] ^ 8'hAA);
        m[0] = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        bus_op(1'b0, BASE + 32'h0, '0);
        bus_op(1'b0, BASE + 32'h8, '0);
        bus_op(1'b1, BASE + 32'h4, 32'h1234_56AA);
        chk("leds_aa", 64'(leds), 64'(8'hAA));

        // two-cycle glitch must be filtered
        switches = 8'h55;
        repeat (2) @(posedge clk);
        #1;
        switches = 8'hAA;
        repeat (10) @(posedge clk);
        #1;
        bus_op(1'b0, BASE + 32'h0, '0);
        bus_op(1'b0, BASE + 32'h8, '0);

        // interrupt on bit0, cleared by W1C one cycle after commit
        bus_op(1'b1, BASE + 32'h8, 32'hFF);
        bus_op(1'b1, BASE + 32'hC, 32'h01);
        chk("irq_idle", 64'(irq), 64'(irq_model()));
        settle_switches(8'hAB);
        chk("irq_set", 64'(irq), 64'(1));
        bus_op(1'b1, BASE + 32'h8, 32'h01);
        chk("irq_lag", 64'(irq_resp), 64'(1));
        chk("irq_clr", 64'(irq), 64'(0));

        // W1C committing on the same edge as a new bit0 change: the set wins
        switches = 8'hAA;
        repeat (DEB + 1) @(posedge clk);
        #1;
        bus_op(1'b1, BASE + 32'h8, 32'h01);
        m[2] = m[2] | (m[0] ^ 8'hAA);
        m[0] = 8'hAA;
        bus_op(1'b0, BASE + 32'h8, '0);
        chk("irq_coincide", 64'(irq), 64'(1));
        // W1C two edges after the change does clear it
        bus_op(1'b1, BASE + 32'h8, 32'h01);
        switches = 8'hAB;
        repeat (DEB + 3) @(posedge clk);
        #1;
        m[2] = m[2] | (m[0] ^ 8'hAB);
        m[0] = 8'hAB;
        bus_op(1'b1, BASE + 32'h8, 32'h01);
        bus_op(1'b0, BASE + 32'h8, '0);
        chk("irq_late_clr", 64'(irq), 64'(0));

        // bad addresses and a store to the read-only SW register
        bus_op(1'b0, BASE + 32'h10, '0);
        bus_op(1'b0, BASE + 32'h6, '0);
        bus_op(1'b1, BASE + 32'h10, 32'h0000_0011);
        bus_op(1'b1, BASE + 32'h5, 32'h0000_0022);
        bus_op(1'b1, BASE + 32'h0, 32'h0000_0000);
        bus_op(1'b0, BASE + 32'h0, '0);
        bus_op(1'b0, BASE + 32'h4, '0);

        // random traffic
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                v = 8'($urandom);
                settle_switches(v);
            end else begin
                case ($urandom_range(0, 7))
                    0, 1, 2, 3: a = BASE + 32'($urandom_range(0, 3) * 4);
                    4:          a = BASE + 32'h10;
                    5:          a = BASE + 32'($urandom_range(0, 3) * 4 + $urandom_range(1, 3));
                    6:          a = $urandom;
                    default:    a = BASE - 32'h4;
                endcase
                bus_op(1'($urandom), a, $urandom);
            end
            chk("irq_rand", 64'(irq), 64'(irq_model()));
        end

        // reset during the RESP cycle of an LED store: access dropped
        bus_if.bus_req   = 1'b1;
        bus_if.bus_we    = 1'b1;
        bus_if.bus_addr  = BASE + 32'h4;
        bus_if.bus_wdata = 32'h0000_003C;
        @(posedge clk); #1;
        rst_n          = 1'b0;
        bus_if.bus_req = 1'b0;
        #2;
        chk("midrst_leds",  64'(leds), 64'(0));
        chk("midrst_ready", 64'(bus_if.bus_ready), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) m[i] = '0;
        repeat (12) @(posedge clk);
        #1;
        m[2] = switches;
        m[0] = switches;
        chk("post_rst_leds", 64'(leds), 64'(0));
        bus_op(1'b0, BASE + 32'h4, '0);
        bus_op(1'b0, BASE + 32'h0, '0);
        bus_op(1'b0, BASE + 32'h8, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("pending_left", 64'(q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
